// File: rtl/fifo_main_pop_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_main_pop_ctrl
//
// Pops words from a first-word-fall-through main FIFO and forwards each one,
// one cycle later, to a per-VC demux. The target VC of the head word is taken
// from a VC-id field inside the word. A pop is held off while that VC is
// almost full (head-of-line blocking: nothing behind the head may overtake),
// while software asserts pause, or while the FIFO is empty.
//
// Handshake: Main_rd is a same-cycle pop strobe. The FIFO presents its head
// on Main_data_out whenever Main_empty is low, and the word counts as
// consumed on every rising edge where Main_rd is high. demux_vcid_valid_in
// is a one-cycle qualifier with no ready; the demux must accept the word on
// the cycle it is valid. Its backpressure reaches this block only through
// VC_almost_full.
//
// Optional build macro:
//   LEGACY_ANY_AF_EN - when defined, any asserted VC_almost_full bit blocks
//                      the pop, regardless of which VC the head word targets.
//
// Ports:
//   clk                 in   clock, all state changes on its rising edge
//   reset               in   asynchronous, active-high reset
//   Main_empty          in   main FIFO empty
//   Main_data_out       in   [DATA_W]  head word of the main FIFO
//   VC_almost_full      in   [NUM_VC]  per-VC almost-full flags
//   pause               in   software hold, no pops while high
//   Main_rd             out  combinational pop strobe to the main FIFO
//   demux_vcid_in       out  [DATA_W]  registered word to the demux
//   demux_vcid_valid_in out  registered valid for demux_vcid_in
//   demux_vc_sel        out  [NUM_VC]  registered one-hot target VC
//   state               out  [2]  FSM state (IDLE=0 RUN=1 STALL=2 HOLD=3)
//   stall_cnt           out  [STALL_CNT_W]  saturating count of STALL cycles
// ---------------------------------------------------------------------------
module fifo_main_pop_ctrl #(
    parameter int DATA_W      = 6,
    parameter int NUM_VC      = 2,
    parameter int VCID_LSB    = 4,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Main_empty,
    input  logic [DATA_W-1:0]      Main_data_out,
    input  logic [NUM_VC-1:0]      VC_almost_full,
    input  logic                   pause,
    output logic                   Main_rd,
    output logic [DATA_W-1:0]      demux_vcid_in,
    output logic                   demux_vcid_valid_in,
    output logic [NUM_VC-1:0]      demux_vc_sel,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int VCID_W = $clog2(NUM_VC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                  cur_state;
    state_t                  nxt_state;
    logic                    pop_ok;
    logic                    blocked;
    logic [VCID_W-1:0]       tgt;
    logic [NUM_VC-1:0]       tgt_onehot;
    logic [STALL_CNT_W-1:0]  stall_cnt_nxt;

    assign tgt        = Main_data_out[VCID_LSB +: VCID_W];
    assign tgt_onehot = NUM_VC'(1) << tgt;

`ifdef LEGACY_ANY_AF_EN
    // Older behaviour: a single congested VC halts the whole stream.
    assign blocked = |VC_almost_full;
`else
    // Only the VC the head word is heading for can block it.
    assign blocked = VC_almost_full[tgt];
`endif

    // Next state and pop decision. The priority order makes an empty FIFO
    // report IDLE even when the stale head would also be blocked.
    always_comb begin
        nxt_state = ST_RUN;
        pop_ok    = 1'b0;
        if (pause) begin
            nxt_state = ST_HOLD;
        end else if (Main_empty) begin
            nxt_state = ST_IDLE;
        end else if (blocked) begin
            nxt_state = ST_STALL;
        end else begin
            nxt_state = ST_RUN;
            pop_ok    = 1'b1;
        end
    end

    // Reset gates the strobe directly so the FIFO never sees a pop while
    // reset is high, including the edge on which it is released.
    assign Main_rd = pop_ok && !reset;

    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (nxt_state == ST_STALL) begin
            if (stall_cnt != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_nxt = stall_cnt + STALL_CNT_W'(1);
            end
        end else if (nxt_state == ST_RUN) begin
            stall_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            stall_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    // Output register: the popped word appears one cycle after its pop and
    // everything reads zero on cycles without a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            demux_vcid_in       <= '0;
            demux_vcid_valid_in <= 1'b0;
            demux_vc_sel        <= '0;
        end else if (Main_rd) begin
            demux_vcid_in       <= Main_data_out;
            demux_vcid_valid_in <= 1'b1;
            demux_vc_sel        <= tgt_onehot;
        end else begin
            demux_vcid_in       <= '0;
            demux_vcid_valid_in <= 1'b0;
            demux_vc_sel        <= '0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_fifo_main_pop_ctrl.sv
module tb_fifo_main_pop_ctrl;
  localparam int DATA_W   = 6;
  localparam int NUM_VC   = 2;
  localparam int VCID_LSB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              main_empty;
  logic [DATA_W-1:0] main_data_out;
  logic [NUM_VC-1:0] vc_almost_full;
  logic              pause;

  logic              main_rd;
  logic [DATA_W-1:0] dmx_data;
  logic              dmx_valid;
  logic [NUM_VC-1:0] dmx_sel;
  logic [1:0]        dut_state;
  logic [7:0]        dut_cnt;

  logic              w2_main_rd;
  logic [DATA_W-1:0] w2_data;
  logic              w2_valid;
  logic [NUM_VC-1:0] w2_sel;
  logic [1:0]        w2_state;
  logic [1:0]        w2_cnt;

  fifo_main_pop_ctrl #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .VCID_LSB(VCID_LSB), .STALL_CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .Main_empty(main_empty), .Main_data_out(main_data_out),
    .VC_almost_full(vc_almost_full), .pause(pause), .Main_rd(main_rd),
    .demux_vcid_in(dmx_data), .demux_vcid_valid_in(dmx_valid), .demux_vc_sel(dmx_sel),
    .state(dut_state), .stall_cnt(dut_cnt)
  );

  // narrow-counter instance, used for the saturation boundary
  fifo_main_pop_ctrl #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .VCID_LSB(VCID_LSB), .STALL_CNT_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .Main_empty(main_empty), .Main_data_out(main_data_out),
    .VC_almost_full(vc_almost_full), .pause(pause), .Main_rd(w2_main_rd),
    .demux_vcid_in(w2_data), .demux_vcid_valid_in(w2_valid), .demux_vc_sel(w2_sel),
    .state(w2_state), .stall_cnt(w2_cnt)
  );

  // reference model: the main FIFO contents, delivered-word scoreboard, and
  // the state / counters derived from the pop rules
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int m_state;
  int m_cnt8;
  int m_cnt2;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present inputs, check the combinational strobe, let the
  // edge happen, then check every registered output against the model.
  task automatic drive_cycle(input logic p, input logic [NUM_VC-1:0] af);
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] word;
    bit emp, blk, pop;
    int tgt, nxt;
    emp  = (fifo_q.size() == 0);
    head = emp ? DATA_W'($urandom_range(0, 63)) : fifo_q[0];
    pause = p;
    vc_almost_full = af;
    main_empty = emp;
    main_data_out = head;
    tgt = (int'(head) >> VCID_LSB) % NUM_VC;
`ifdef LEGACY_ANY_AF_EN
    blk = (af != 0);
`else
    blk = af[tgt];
`endif
    pop = !p && !emp && !blk;
    if (p) nxt = 3;
    else if (emp) nxt = 0;
    else if (blk) nxt = 2;
    else nxt = 1;
    #1;
    check_eq("main_rd", main_rd, pop);
    check_eq("w2_main_rd", w2_main_rd, pop);
    if (pop) begin
      exp_q.push_back(head);
      fifo_q.delete(0);
    end
    m_state = nxt;
    if (nxt == 2) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end else if (nxt == 1) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
    @(posedge clk);
    #1;
    check_eq("valid", dmx_valid, pop);
    if (pop) begin
      word = exp_q.pop_front();
      check_eq("data", dmx_data, word);
      check_eq("sel", dmx_sel, 1 << tgt);
    end else begin
      check_eq("data_idle", dmx_data, 0);
      check_eq("sel_idle", dmx_sel, 0);
    end
    check_eq("state", dut_state, m_state);
    check_eq("stall_cnt", dut_cnt, m_cnt8);
    check_eq("w2_stall_cnt", w2_cnt, m_cnt2);
  endtask

  // Asserted right after an edge; held over one edge with the FIFO still
  // presenting words, then released between edges.
  task automatic apply_reset();
    main_empty = (fifo_q.size() == 0);
    main_data_out = main_empty ? '0 : fifo_q[0];
    pause = 1'b0;
    vc_almost_full = '0;
    reset = 1'b1;
    #1;
    check_eq("rst_main_rd", main_rd, 0);
    check_eq("rst_valid", dmx_valid, 0);
    check_eq("rst_data", dmx_data, 0);
    check_eq("rst_sel", dmx_sel, 0);
    check_eq("rst_state", dut_state, 0);
    check_eq("rst_cnt", dut_cnt, 0);
    @(posedge clk);
    #1;
    check_eq("rst_edge_valid", dmx_valid, 0);
    reset = 1'b0;
    m_state = 0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    pause = 1'b0;
    main_empty = 1'b1;
    main_data_out = '0;
    vc_almost_full = '0;
    m_state = 0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_valid", dmx_valid, 0);
    check_eq("init_state", dut_state, 0);
    check_eq("init_cnt", dut_cnt, 0);
    check_eq("init_main_rd", main_rd, 0);
    reset = 1'b0;

    // first pop straight after release, tgt=1
    fifo_q = '{6'h15};
    drive_cycle(1'b0, 2'b00);
    check_eq("first_sel", dmx_sel, 2'b10);

    // head blocked by its own VC for 3 cycles, then released
    fifo_q = '{6'h0A, 6'h01};
    repeat (3) drive_cycle(1'b0, 2'b01);
    check_eq("stall3_cnt", dut_cnt, 3);
    drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b0, 2'b00);

    // only the other VC is almost full
    fifo_q = '{6'h05};
    drive_cycle(1'b0, 2'b10);
    drive_cycle(1'b0, 2'b00);

    // empty together with a blocking almost-full must stay IDLE
    drive_cycle(1'b0, 2'b11);

    // 4-word stream, pause on the third
    fifo_q = '{6'h01, 6'h12, 6'h03, 6'h14};
    drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b1, 2'b00);
    check_eq("pause_state", dut_state, 3);
    drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b0, 2'b00);

    // reset while a 6'h3F word is valid
    fifo_q = '{6'h3F, 6'h21, 6'h02};
    drive_cycle(1'b0, 2'b00);
    check_eq("pre_rst_data", dmx_data, 6'h3F);
    apply_reset();
    drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b0, 2'b00);

    // six stall cycles: narrow counter saturates at 3, wide one reaches 6
    fifo_q = '{6'h10};
    repeat (6) drive_cycle(1'b0, 2'b10);
    check_eq("sat_w2", w2_cnt, 3);
    check_eq("sat_w8", dut_cnt, 6);
    drive_cycle(1'b0, 2'b00);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic p;
      logic [NUM_VC-1:0] af;
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8)
        fifo_q.push_back(DATA_W'($urandom_range(0, 63)));
      p  = ($urandom_range(0, 7) == 0);
      af = ($urandom_range(0, 2) == 0) ? NUM_VC'($urandom_range(1, 3)) : '0;
      if ($urandom_range(0, 149) == 0) apply_reset();
      else drive_cycle(p, af);
    end

    while (fifo_q.size() != 0) drive_cycle(1'b0, 2'b00);
    drive_cycle(1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
